// File: rtl/lc3_bus_arbiter.sv
// LC-3 shared-bus arbiter: four gate sources, one-hot registered grant, lockable bursts.
// Define LC3_BUS_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority (source 0 first).
module lc3_bus_arbiter #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [3:0]         Req,
    input  logic [3:0]         Lock,
    input  logic [3:0]         SetCC,
    input  logic [4*WIDTH-1:0] Data_In,
    output logic [3:0]         Grant,
    output logic [WIDTH-1:0]   Bus_Out,
    output logic               Bus_Valid,
    output logic               Load_NZP_Logic
);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    state_t     r_state;
    logic [3:0] r_grant;
    logic [1:0] r_last;
    logic [3:0] r_hold;
    logic       r_cc;

    state_t     w_state_nxt;
    logic [3:0] w_grant_nxt;
    logic [1:0] w_last_nxt;
    logic [3:0] w_hold_nxt;
    logic       w_cc_nxt;

    logic       w_own;
    logic       w_want;
    logic       w_keep;
    logic       w_forced;
    logic [3:0] w_cand;
    logic       w_found;
    logic [1:0] w_win;
    logic [WIDTH-1:0] w_bus;

    // While owning, r_last always names the current owner.
    assign w_own    = (r_state == S_OWN);
    assign w_want   = w_own && Req[r_last] && Lock[r_last];
    assign w_keep   = w_want && (r_hold < HOLD_MAX);
    assign w_forced = w_want && (r_hold >= HOLD_MAX);
    assign w_cand   = Req & ~(w_forced ? r_grant : 4'b0000);

    always_comb begin
        logic [1:0] idx;
        w_found = 1'b0;
        w_win   = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < 4; k++) begin
`ifdef LC3_BUS_ARB_ROUND_ROBIN_EN
            idx = r_last + 2'(k + 1);
`else
            idx = 2'(k);
`endif
            if (!w_found && w_cand[idx]) begin
                w_found = 1'b1;
                w_win   = idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
        w_last_nxt  = r_last;
        w_hold_nxt  = 4'd0;
        w_cc_nxt    = 1'b0;
        case (r_state)
            S_IDLE, S_OWN: begin
                if (w_keep) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = r_grant;
                    w_hold_nxt  = r_hold + 4'd1;
                    w_cc_nxt    = r_cc;
                end else if (w_found) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = 4'b0001 << w_win;
                    w_last_nxt  = w_win;
                    w_hold_nxt  = 4'd1;
                    w_cc_nxt    = SetCC[w_win];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_grant <= 4'b0000;
            r_last  <= 2'd3;
            r_hold  <= 4'd0;
            r_cc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
            r_cc    <= w_cc_nxt;
        end
    end

    always_comb begin
        w_bus = '0;
        for (int i = 0; i < 4; i++) begin
            w_bus = w_bus | (Data_In[i*WIDTH +: WIDTH] & {WIDTH{r_grant[i]}});
        end
    end

    assign Grant          = r_grant;
    assign Bus_Out        = w_bus;
    assign Bus_Valid      = w_own;
    assign Load_NZP_Logic = r_cc & w_own;

endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// Directed bench for lc3_bus_arbiter; expectations follow LC3_BUS_ARB_ROUND_ROBIN_EN.
module tb_lc3_bus_arbiter;

    logic        Clk;
    logic        Reset;
    logic [3:0]  Req;
    logic [3:0]  Lock;
    logic [3:0]  SetCC;
    logic [63:0] Data_In;
    logic [3:0]  Grant;
    logic [15:0] Bus_Out;
    logic        Bus_Valid;
    logic        Load_NZP_Logic;

    int n_cmp = 0;
    int n_bad = 0;
    logic tb_n;

    lc3_bus_arbiter #(.WIDTH(16), .MAX_HOLD(4)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Req            (Req),
        .Lock           (Lock),
        .SetCC          (SetCC),
        .Data_In        (Data_In),
        .Grant          (Grant),
        .Bus_Out        (Bus_Out),
        .Bus_Valid      (Bus_Valid),
        .Load_NZP_Logic (Load_NZP_Logic)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Stand-in for the NZP register, which captures on the falling edge.
    always @(negedge Clk) begin
        if (Reset) tb_n = 1'b0;
        else if (Load_NZP_Logic) tb_n = Bus_Out[15];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Req   = 4'b0000;
        Lock  = 4'b0000;
        SetCC = 4'b0000;
        step();
        Reset = 1'b0;
    endtask

    logic [3:0] rr_seq [5];
    logic [3:0] exp_g;

    initial begin
        rr_seq[0] = 4'b0001;
        rr_seq[1] = 4'b0010;
        rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000;
        rr_seq[4] = 4'b0001;
        Data_In = {16'h3333, 16'h2222, 16'h1111, 16'h8000};
        tb_n = 1'b0;
        do_reset();
        check("rst_grant", 32'(Grant), 32'h0);
        check("rst_valid", 32'(Bus_Valid), 32'h0);
        check("rst_nzp", 32'(Load_NZP_Logic), 32'h0);
        check("rst_bus", 32'(Bus_Out), 32'h0);

        Req = 4'b0001;
        SetCC = 4'b0001;
        step();
        check("t1_grant", 32'(Grant), 32'h1);
        check("t1_bus", 32'(Bus_Out), 32'h8000);
        check("t1_valid", 32'(Bus_Valid), 32'h1);
        check("t1_nzp", 32'(Load_NZP_Logic), 32'h1);
        @(negedge Clk);
        #1;
        check("t1_n", 32'(tb_n), 32'h1);
        Req = 4'b0000;
        SetCC = 4'b0000;
        step();
        check("t1_idle", 32'(Grant), 32'h0);
        check("t1_idle_bus", 32'(Bus_Out), 32'h0);

        do_reset();
        Req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
`ifdef LC3_BUS_ARB_ROUND_ROBIN_EN
            exp_g = rr_seq[i];
`else
            exp_g = 4'b0001;
`endif
            check($sformatf("t2_grant%0d", i), 32'(Grant), 32'(exp_g));
            check($sformatf("t2_valid%0d", i), 32'(Bus_Valid), 32'h1);
        end
        Req = 4'b0000;
        step();

        do_reset();
        Req = 4'b0100;
        Lock = 4'b0100;
        step();
        Req = 4'b0110;
        check("t3_hold1", 32'(Grant), 32'h4);
        check("t3_bus", 32'(Bus_Out), 32'h2222);
        for (int i = 2; i <= 4; i++) begin
            step();
            check($sformatf("t3_hold%0d", i), 32'(Grant), 32'h4);
        end
        step();
        check("t3_forced", 32'(Grant), 32'h2);
        check("t3_forced_bus", 32'(Bus_Out), 32'h1111);
        step();
`ifdef LC3_BUS_ARB_ROUND_ROBIN_EN
        check("t3_after", 32'(Grant), 32'h4);
`else
        check("t3_after", 32'(Grant), 32'h2);
`endif
        Req = 4'b0000;
        Lock = 4'b0000;
        step();

        do_reset();
        Data_In[31:16] = 16'h0000;
        Req = 4'b0010;
        Lock = 4'b0010;
        SetCC = 4'b0000;
        step();
        check("t4_valid", 32'(Bus_Valid), 32'h1);
        check("t4_nzp0", 32'(Load_NZP_Logic), 32'h0);
        check("t4_bus", 32'(Bus_Out), 32'h0);
        SetCC = 4'b0010;
        step();
        check("t4_nzp_tog1", 32'(Load_NZP_Logic), 32'h0);
        SetCC = 4'b0000;
        step();
        check("t4_nzp_tog2", 32'(Load_NZP_Logic), 32'h0);
        Req = 4'b0000;
        step();
        check("t4_idle", 32'(Bus_Valid), 32'h0);
        Req = 4'b0010;
        SetCC = 4'b0010;
        step();
        check("t4_nzp1", 32'(Load_NZP_Logic), 32'h1);
        SetCC = 4'b0000;
        step();
        check("t4_nzp_held", 32'(Load_NZP_Logic), 32'h1);
        Req = 4'b0000;
        Lock = 4'b0000;
        step();

        do_reset();
        Data_In[31:16] = 16'h1111;
        Req = 4'b1000;
        Lock = 4'b1000;
        SetCC = 4'b1000;
        step();
        check("t5_b1", 32'(Grant), 32'h8);
        step();
        check("t5_b2", 32'(Grant), 32'h8);
        Reset = 1'b1;
        step();
        check("t5_rst_grant", 32'(Grant), 32'h0);
        check("t5_rst_valid", 32'(Bus_Valid), 32'h0);
        check("t5_rst_nzp", 32'(Load_NZP_Logic), 32'h0);
        check("t5_rst_bus", 32'(Bus_Out), 32'h0);
        Reset = 1'b0;
        Req = 4'b1001;
        Lock = 4'b0000;
        SetCC = 4'b0000;
        step();
        check("t5_regrant", 32'(Grant), 32'h1);
        Req = 4'b0000;
        step();

        do_reset();
        Req = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
`ifdef LC3_BUS_ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0) ? 4'b0010 : 4'b1000;
`else
            exp_g = 4'b0010;
`endif
            check($sformatf("t6_grant%0d", i), 32'(Grant), 32'(exp_g));
        end
        Req = 4'b0000;
        step();
        check("t6_idle", 32'(Grant), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
